// File: rtl/bcd_field_setter.sv
// Edits NFIELDS two-digit BCD fields with per-field min/max bounds and emits a commit pulse on leaving edit mode.
// Optional hold-to-repeat for INC/DEC is built only when HOLD_REPEAT_EN is defined.
module bcd_field_setter #(
  parameter int unsigned            NFIELDS       = 4,
  parameter logic [8*NFIELDS-1:0]   FIELD_MIN_VEC = {8'h01, 8'h00, 8'h00, 8'h00},
  parameter logic [8*NFIELDS-1:0]   FIELD_MAX_VEC = {8'h31, 8'h23, 8'h59, 8'h59},
  parameter int unsigned            SELW          = 2,
  parameter int unsigned            REPEAT_DELAY  = 500,
  parameter int unsigned            REPEAT_RATE   = 100
) (
  input  logic                   CLK1K,
  input  logic                   RST,
  input  logic                   EDIT_EN,
  input  logic                   KEY_NEXT,
  input  logic                   KEY_INC,
  input  logic                   KEY_DEC,
  input  logic [8*NFIELDS-1:0]   LIVE_VAL,
  output logic [8*NFIELDS-1:0]   SET_VAL,
  output logic [SELW-1:0]        SEL_FIELD,
  output logic                   EDITING,
  output logic                   COMMIT
);

  if ((2**SELW) < NFIELDS || REPEAT_RATE < 1 || REPEAT_DELAY < REPEAT_RATE) begin : g_cfg_check
    $error("bcd_field_setter: invalid SELW/REPEAT_DELAY/REPEAT_RATE configuration");
  end

  typedef enum logic {IDLE, EDIT} state_t;
  state_t state;

  logic next_q, inc_q, dec_q;
  logic next_ev, inc_ev, dec_ev;
  logic inc_fire, dec_fire, rep_fire;
  logic [8*NFIELDS-1:0] set_nxt;

  assign next_ev = KEY_NEXT & ~next_q;
  assign inc_ev  = KEY_INC  & ~inc_q;
  assign dec_ev  = KEY_DEC  & ~dec_q;

  function automatic logic bcd_bad(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
    return (v[7:4] > 4'd9) || (v[3:0] > 4'd9) || (v < lo) || (v > hi);
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
    if (v == hi || bcd_bad(v, lo, hi)) return lo;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
    if (v == lo) return hi;
    if (bcd_bad(v, lo, hi)) return lo;
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

`ifdef HOLD_REPEAT_EN
  localparam int unsigned CW = $clog2(REPEAT_DELAY + 1);
  logic [CW-1:0] rep_cnt;
  logic          hold_alone;

  // Counter runs while exactly one of INC/DEC is held in EDIT; reaching DELAY fires and
  // rewinds so the following fires land every RATE cycles.
  assign hold_alone = (state == EDIT) && EDIT_EN && (KEY_INC ^ KEY_DEC) && !next_ev;
  assign rep_fire   = hold_alone && (rep_cnt == CW'(REPEAT_DELAY));

  always_ff @(posedge CLK1K) begin
    if (RST || !hold_alone)
      rep_cnt <= '0;
    else if (rep_fire)
      rep_cnt <= CW'(REPEAT_DELAY - REPEAT_RATE + 1);
    else
      rep_cnt <= rep_cnt + 1'b1;
  end
`else
  assign rep_fire = 1'b0;
`endif

  assign inc_fire = inc_ev | (rep_fire & KEY_INC);
  assign dec_fire = dec_ev | (rep_fire & KEY_DEC);

  always_comb begin
    set_nxt = SET_VAL;
    for (int unsigned i = 0; i < NFIELDS; i++) begin
      if (SEL_FIELD == SELW'(i)) begin
        if (inc_fire && !dec_fire)
          set_nxt[8*i +: 8] = bcd_inc(SET_VAL[8*i +: 8], FIELD_MIN_VEC[8*i +: 8], FIELD_MAX_VEC[8*i +: 8]);
        else if (dec_fire && !inc_fire)
          set_nxt[8*i +: 8] = bcd_dec(SET_VAL[8*i +: 8], FIELD_MIN_VEC[8*i +: 8], FIELD_MAX_VEC[8*i +: 8]);
      end
    end
  end

  always_ff @(posedge CLK1K) begin
    if (RST) begin
      state     <= IDLE;
      SET_VAL   <= FIELD_MIN_VEC;
      SEL_FIELD <= '0;
      EDITING   <= 1'b0;
      COMMIT    <= 1'b0;
      next_q    <= 1'b1;
      inc_q     <= 1'b1;
      dec_q     <= 1'b1;
    end else begin
      next_q <= KEY_NEXT;
      inc_q  <= KEY_INC;
      dec_q  <= KEY_DEC;
      COMMIT <= 1'b0;
      case (state)
        IDLE: begin
          SET_VAL <= LIVE_VAL;
          if (EDIT_EN) begin
            state     <= EDIT;
            SEL_FIELD <= '0;
            EDITING   <= 1'b1;
          end
        end
        EDIT: begin
          if (!EDIT_EN) begin
            state   <= IDLE;
            COMMIT  <= 1'b1;
            EDITING <= 1'b0;
          end else begin
            SET_VAL <= set_nxt;
            if (next_ev)
              SEL_FIELD <= (SEL_FIELD == SELW'(NFIELDS - 1)) ? '0 : SEL_FIELD + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_field_setter.sv
// Bench for bcd_field_setter: decimal-arithmetic reference model checked every cycle,
// directed scenarios with literal expectations, then randomized stimulus.
module tb_bcd_field_setter;

  localparam logic [31:0] MINV = {8'h01, 8'h00, 8'h00, 8'h00};
  localparam logic [31:0] MAXV = {8'h31, 8'h23, 8'h59, 8'h59};
  localparam int D = 500;
  localparam int R = 100;

  logic        CLK1K = 1'b0;
  logic        RST, EDIT_EN, KEY_NEXT, KEY_INC, KEY_DEC;
  logic [31:0] LIVE_VAL, SET_VAL;
  logic [1:0]  SEL_FIELD;
  logic        EDITING, COMMIT;

  always #5 CLK1K = ~CLK1K;

  bcd_field_setter #(
    .NFIELDS(4), .FIELD_MIN_VEC(MINV), .FIELD_MAX_VEC(MAXV),
    .SELW(2), .REPEAT_DELAY(D), .REPEAT_RATE(R)
  ) dut (
    .CLK1K(CLK1K), .RST(RST), .EDIT_EN(EDIT_EN), .KEY_NEXT(KEY_NEXT),
    .KEY_INC(KEY_INC), .KEY_DEC(KEY_DEC), .LIVE_VAL(LIVE_VAL),
    .SET_VAL(SET_VAL), .SEL_FIELD(SEL_FIELD), .EDITING(EDITING), .COMMIT(COMMIT)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] m_f[4];
  int         m_sel;
  bit         m_edit, m_commit;
  bit         pn, pi, pd;
  int         m_hold;

  bit          cur_en;
  logic [31:0] cur_live;

  function automatic int todec(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] tobcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  function automatic bit m_bad(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
    if (v[7:4] > 9 || v[3:0] > 9) return 1'b1;
    return todec(v) < todec(lo) || todec(v) > todec(hi);
  endfunction

  function automatic logic [7:0] m_inc(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
    if (m_bad(v, lo, hi) || v == hi) return lo;
    return tobcd(todec(v) + 1);
  endfunction

  function automatic logic [7:0] m_dec(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
    if (v == lo) return hi;
    if (m_bad(v, lo, hi)) return lo;
    return tobcd(todec(v) - 1);
  endfunction

  function automatic logic [7:0] lo_of(input int i);
    return MINV[8*i +: 8];
  endfunction

  function automatic logic [7:0] hi_of(input int i);
    return MAXV[8*i +: 8];
  endfunction

  task automatic model_step();
    bit ne, ie, de, fi, fd, rep;
    if (RST) begin
      for (int i = 0; i < 4; i++) m_f[i] = lo_of(i);
      m_sel = 0; m_edit = 0; m_commit = 0;
      pn = 1; pi = 1; pd = 1; m_hold = 0;
      return;
    end
    ne = KEY_NEXT && !pn;
    ie = KEY_INC && !pi;
    de = KEY_DEC && !pd;
    rep = 0;
`ifdef HOLD_REPEAT_EN
    if (m_edit && EDIT_EN && (KEY_INC != KEY_DEC) && !ne) begin
      rep = (m_hold >= D) && ((m_hold - D) % R == 0);
      m_hold++;
    end else m_hold = 0;
`endif
    m_commit = 0;
    if (!m_edit) begin
      for (int i = 0; i < 4; i++) m_f[i] = LIVE_VAL[8*i +: 8];
      if (EDIT_EN) begin m_edit = 1; m_sel = 0; end
    end else if (!EDIT_EN) begin
      m_commit = 1; m_edit = 0;
    end else begin
      fi = ie || (rep && KEY_INC);
      fd = de || (rep && KEY_DEC);
      if (fi && !fd) m_f[m_sel] = m_inc(m_f[m_sel], lo_of(m_sel), hi_of(m_sel));
      else if (fd && !fi) m_f[m_sel] = m_dec(m_f[m_sel], lo_of(m_sel), hi_of(m_sel));
      if (ne) m_sel = (m_sel + 1) % 4;
    end
    pn = KEY_NEXT; pi = KEY_INC; pd = KEY_DEC;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic compare();
    chk("set_val", SET_VAL, {m_f[3], m_f[2], m_f[1], m_f[0]});
    chk("sel_field", 32'(SEL_FIELD), 32'(m_sel));
    chk("editing", 32'(EDITING), 32'(m_edit));
    chk("commit", 32'(COMMIT), 32'(m_commit));
  endtask

  task automatic cyc(input bit rst, input bit en, input bit kn, input bit ki, input bit kd,
                     input logic [31:0] live);
    RST = rst; EDIT_EN = en; KEY_NEXT = kn; KEY_INC = ki; KEY_DEC = kd; LIVE_VAL = live;
    cur_en = en; cur_live = live;
    @(posedge CLK1K);
    model_step();
    #1 compare();
  endtask

  task automatic press(input bit kn, input bit ki, input bit kd);
    cyc(0, cur_en, kn, ki, kd, cur_live);
    cyc(0, cur_en, 0, 0, 0, cur_live);
  endtask

  task automatic enter_edit(input logic [31:0] live);
    cyc(0, 0, 0, 0, 0, live);
    cyc(0, 0, 0, 0, 0, live);
    cyc(0, 1, 0, 0, 0, live);
  endtask

  initial begin
    bit en, kn, ki, kd;
    // Reset and live tracking
    cyc(1, 0, 0, 0, 0, 32'h15123456);
    cyc(1, 0, 0, 0, 0, 32'h15123456);
    chk("pin_reset_set", SET_VAL, 32'h01000000);
    chk("pin_reset_editing", 32'(EDITING), 32'd0);
    cyc(0, 0, 0, 0, 0, 32'h15123456);
    chk("pin_track", SET_VAL, 32'h15123456);

    // Seconds wrap up and down
    enter_edit(32'h15123459);
    chk("pin_editing", 32'(EDITING), 32'd1);
    press(0, 1, 0);
    chk("pin_sec_inc_wrap", SET_VAL, 32'h15123400);
    press(0, 0, 1);
    chk("pin_sec_dec_wrap", SET_VAL, 32'h15123459);

    // Day and hour bounds
    cyc(0, 0, 0, 0, 0, 32'h01230059);
    enter_edit(32'h01230059);
    repeat (3) press(1, 0, 0);
    chk("pin_sel3", 32'(SEL_FIELD), 32'd3);
    press(0, 0, 1);
    chk("pin_day_dec_wrap", SET_VAL, 32'h31230059);
    repeat (3) press(1, 0, 0);
    press(0, 1, 0);
    chk("pin_hour_inc_wrap", SET_VAL, 32'h31000059);
    press(1, 0, 0);
    press(0, 1, 0);
    chk("pin_day_inc_wrap", SET_VAL, 32'h01000059);

    // Invalid field, simultaneous keys, NEXT+INC
    cyc(0, 0, 0, 0, 0, 32'h0100007A);
    enter_edit(32'h0100007A);
    press(0, 1, 0);
    chk("pin_invalid_inc", SET_VAL, 32'h01000000);
    press(0, 1, 1);
    chk("pin_inc_dec_same", SET_VAL, 32'h01000000);
    repeat (3) press(1, 0, 0);
    press(1, 1, 0);
    chk("pin_next_inc_val", SET_VAL, 32'h02000000);
    chk("pin_next_inc_sel", 32'(SEL_FIELD), 32'd0);

    // Edit minutes to 42 and commit
    press(1, 0, 0);
    repeat (18) press(0, 0, 1);
    chk("pin_min42", SET_VAL, 32'h02004200);
    cyc(0, 0, 0, 0, 0, 32'h11111111);
    chk("pin_commit", 32'(COMMIT), 32'd1);
    chk("pin_commit_val", SET_VAL, 32'h02004200);
    cyc(0, 0, 0, 0, 0, 32'h11111111);
    chk("pin_commit_end", 32'(COMMIT), 32'd0);
    chk("pin_retrack", SET_VAL, 32'h11111111);

    // Reset during edit
    enter_edit(32'h05050505);
    press(0, 1, 0);
    cyc(1, 1, 0, 0, 0, 32'h05050505);
    chk("pin_rst_commit", 32'(COMMIT), 32'd0);
    chk("pin_rst_set", SET_VAL, 32'h01000000);
    chk("pin_rst_editing", 32'(EDITING), 32'd0);

    // Hold INC for 800 cycles after the edge
    cyc(0, 0, 0, 0, 0, 32'h01000000);
    enter_edit(32'h01000000);
    repeat (801) cyc(0, 1, 0, 1, 0, 32'h01000000);
`ifdef HOLD_REPEAT_EN
    chk("pin_hold", SET_VAL, 32'h01000005);
`else
    chk("pin_hold", SET_VAL, 32'h01000001);
`endif
    cyc(0, 1, 0, 0, 0, 32'h01000000);

    // Randomized traffic
    en = 1; kn = 0; ki = 0; kd = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 39) == 0) en = !en;
      if ($urandom_range(0, 3) == 0) kn = !kn;
      if ($urandom_range(0, 3) == 0) ki = !ki;
      if ($urandom_range(0, 3) == 0) kd = !kd;
      cyc($urandom_range(0, 299) == 0, en, kn, ki, kd, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
